// File: rtl/pp_heap_pkg.sv
// Shared types and constants for the partial-product bit-heap sequencer.
package pp_heap_pkg;

  localparam int PP_N  = 30;
  localparam int NCOL  = 2 * PP_N - 1;
  localparam int OUT_W = 2 * PP_N + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    HOLD
  } state_t;

  // Number of partial-product bits that land in column c of an n x n array.
  function automatic int col_height(input int c, input int n);
    return ((c + 1) < (2 * n - 1 - c)) ? (c + 1) : (2 * n - 1 - c);
  endfunction

endpackage

// File: rtl/pp_column_mux.sv
// Selects the partial-product bit each column shift register receives at load step k.
// Short columns are pre-filled with zeros so every column finishes on the same step,
// and the highest-i term of a column is always the last bit shifted in.
module pp_column_mux
  import pp_heap_pkg::*;
#(
  parameter int N = PP_N
) (
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  input  logic [$clog2(N)-1:0] k,
  output logic [2*N-2:0]       sh_bit
);

  localparam int KW = $clog2(N);

  // Per-column AND-array bit for the current step, zero during the pre-fill window.
  always_comb begin
    int h;
    int pre;
    int i;
    int j;
    sh_bit = '0;
    h      = 0;
    pre    = 0;
    i      = 0;
    j      = 0;
    for (int c = 0; c < 2 * N - 1; c++) begin
      h   = col_height(c, N);
      pre = N - h;
      if (int'(k) >= pre) begin
        i         = ((c - N + 1) > 0 ? (c - N + 1) : 0) + int'(k) - pre;
        j         = c - i;
        sh_bit[c] = a[i[KW-1:0]] & b[j[KW-1:0]];
      end
    end
  end

endmodule

// File: rtl/pp_heap_sequencer.sv
// Sequencer for the N x N partial-product bit-heap compressor: accepts one operand pair,
// streams the AND-array into the column shift registers over N cycles, waits out the
// compressor latency and holds the captured product under a valid/ready handshake.
module pp_heap_sequencer
  import pp_heap_pkg::*;
#(
  parameter int N       = PP_N,
  parameter int CMP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             sh_en,
  output logic [2*N-2:0]   sh_bit,
  input  logic [2*N:0]     cmp_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N:0]     out_prod
);

  localparam int KW = $clog2(N);
  localparam int SW = $clog2(CMP_LAT + 2);
  localparam int NC = 2 * N - 1;
  localparam int OW = 2 * N + 1;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [OW-1:0]   prod_q, prod_d;
  logic [NC-1:0]   mux_bit;

  pp_column_mux #(.N(N)) u_mux (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .sh_bit (mux_bit)
  );

  // Control state, counters and the product capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      settle_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      settle_q <= settle_d;
      prod_q   <= prod_d;
    end
  end

  // Operand registers; only meaningful after an accepted handshake, so not reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Next-state and output decode; rst forces the handshake and shift controls low.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    settle_d  = settle_q;
    prod_d    = prod_q;
    a_d       = a_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    sh_en     = 1'b0;
    sh_bit    = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          k_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sh_en  = 1'b1;
        sh_bit = mux_bit;
        if (k_q == KW'(N - 1)) begin
          k_d      = '0;
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      SETTLE: begin
        if (settle_q == SW'(CMP_LAT)) begin
          prod_d   = cmp_dst;
          settle_d = '0;
          state_d  = HOLD;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      sh_en     = 1'b0;
      sh_bit    = '0;
      out_valid = 1'b0;
    end
  end

  assign out_prod = prod_q;

endmodule

// File: tb/tb_pp_heap_sequencer.sv
// Bench for pp_heap_sequencer: models the column shift registers and a combinational
// compressor (weighted popcount of every column), and checks products against a*b.
module tb_pp_heap_sequencer;
  import pp_heap_pkg::*;

  localparam int N  = 30;
  localparam int CL = 0;
  localparam int NC = 2 * N - 1;
  localparam int OW = 2 * N + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic          sh_en;
  logic [NC-1:0] sh_bit;
  logic [OW-1:0] cmp_dst;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_prod;

  int errs   = 0;
  int checks = 0;

  logic [N-1:0] colreg [NC];

  pp_heap_sequencer #(.N(N), .CMP_LAT(CL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .sh_en     (sh_en),
    .sh_bit    (sh_bit),
    .cmp_dst   (cmp_dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  always #5 clk = ~clk;

  // Column shift registers; filled with garbage during reset to model stale contents.
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (sh_en)
        colreg[c] <= {colreg[c][N-2:0], sh_bit[c]};
      else if (rst)
        colreg[c] <= N'($urandom);
    end
  end

  // Compressor: each of the lowest h(c) bits in column c is worth 2^c.
  always_comb begin
    cmp_dst = '0;
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < col_height(c, N); j++)
        cmp_dst = cmp_dst + (OW'(colreg[c][j]) << c);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("start_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    int bad;
    int seen_k;
    logic [N-1:0] a1, b1, a2, b2;
    logic [63:0] p1;
    logic [NC-1:0] exp_bits;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int sent, got, cyc;
    bit accepted;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_sh_en", 64'(sh_en), 64'd0);
    chk("idle_sh_bit", 64'(sh_bit), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_prod", 64'(out_prod), 64'd0);

    // 1: zero operands and latency
    start_op('0, '0);
    wait_out(n);
    chk("t1_latency", 64'(n + 1), 64'(N + CL + 2));
    chk("t1_prod", 64'(out_prod), 64'd0);
    consume();

    // 2: all-ones operands
    start_op({N{1'b1}}, {N{1'b1}});
    wait_out(n);
    chk("t2_prod", 64'(out_prod), 64'h0FFF_FFFF_8000_0001);
    chk("t2_msb", 64'(out_prod[OW-1]), 64'd0);
    consume();

    // 3: a=b=1 bit trace
    start_op(N'(1), N'(1));
    bad = 0;
    seen_k = -1;
    for (int k = 0; k < N; k++) begin
      exp_bits = (k == N - 1) ? NC'(1) : '0;
      if (sh_en !== 1'b1 || sh_bit !== exp_bits) bad++;
      if (sh_bit[0] === 1'b1) seen_k = k;
      @(negedge clk);
    end
    chk("t3_trace_bad_steps", 64'(bad), 64'd0);
    chk("t3_bit0_step", 64'(seen_k), 64'(N - 1));
    chk("t3_sh_en_after", 64'(sh_en), 64'd0);
    wait_out(n);
    chk("t3_prod", 64'(out_prod), 64'd1);
    consume();

    // 4: backpressure in HOLD
    a1 = N'($urandom); b1 = N'($urandom);
    a2 = N'($urandom); b2 = N'($urandom);
    start_op(a1, b1);
    wait_out(n);
    p1 = 64'(a1) * 64'(b1);
    chk("t4_prod1", 64'(out_prod), p1);
    in_a = a2; in_b = b2; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (out_valid !== 1'b1 || 64'(out_prod) !== p1 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("t4_stall_bad_cycles", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("t4_idle_out_valid", 64'(out_valid), 64'd0);
    chk("t4_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_accepted", 64'(sh_en), 64'd1);
    wait_out(n);
    chk("t4_prod2", 64'(out_prod), 64'(a2) * 64'(b2));
    consume();

    // 5: reset during LOAD at step 12
    start_op(N'($urandom), N'($urandom));
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_sh_en", 64'(sh_en), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("t5_no_out_valid", 64'(bad), 64'd0);
    start_op(N'(32'h2AAA_AAAA), N'(32'h1555_5555));
    wait_out(n);
    chk("t5_prod", 64'(out_prod), 64'h2AAA_AAAA * 64'h1555_5555);
    consume();

    // 6: random back-to-back with random backpressure
    sent = 0; got = 0; cyc = 0; accepted = 1'b0;
    while (got < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (accepted) in_valid = 1'b0;
      accepted = 1'b0;
      if (sent < 200 && !in_valid && $urandom_range(1, 0) == 1) begin
        in_valid = 1'b1;
        in_a = N'($urandom);
        in_b = N'($urandom);
      end
      out_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(64'(in_a) * 64'(in_b));
        sent++;
        accepted = 1'b1;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk("t6_prod", 64'(out_prod), e);
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t6_count", 64'(got), 64'd200);
    chk("t6_leftover", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
